// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Two-approach (North-South / East-West) traffic controller. Car-detect
//   requests are latched into pending bits. Green is granted round-robin
//   between the approaches, with minimum/maximum green, fixed yellow and a
//   minimum all-red clearance. force_red drives the junction to all-red as fast
//   as the yellow interval allows.
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   ns_car     in   car present on the North-South approach (level)
//   ew_car     in   car present on the East-West approach (level)
//   force_red  in   override: yield green, hold all-red while asserted
//   ns_light   out  NS light code (0 RED, 1 GREEN, 2 YELLOW), registered
//   ew_light   out  EW light code, registered
//   phase_done out  one-cycle pulse after each YELLOW->ALL_RED transition
//   serving_ns out  1 while NS is GREEN or YELLOW
module intersection_scheduler #(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MAX_GREEN   = 12,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned TW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       force_red,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       phase_done,
  output logic       serving_ns
);

  typedef enum logic [2:0] {
    ALL_RED,
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW
  } state_e;

  localparam logic [TW-1:0] MIN_G_LAST  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_G_LAST  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_TIME - 1);

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_GREEN  = 2'd1;
  localparam logic [1:0] L_YELLOW = 2'd2;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ns_pend_q, ns_pend_d;
  logic          ew_pend_q, ew_pend_d;
  logic          last_ns_q, last_ns_d;
  logic [1:0]    ns_light_q, ew_light_q;
  logic          phase_done_q, serving_ns_q;

  function automatic logic [1:0] ns_code(input state_e s);
    case (s)
      NS_GREEN:  ns_code = L_GREEN;
      NS_YELLOW: ns_code = L_YELLOW;
      default:   ns_code = L_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_code(input state_e s);
    case (s)
      EW_GREEN:  ew_code = L_GREEN;
      EW_YELLOW: ew_code = L_YELLOW;
      default:   ew_code = L_RED;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    last_ns_d = last_ns_q;
    case (state_q)
      ALL_RED: begin
        if (timer_q >= ALLRED_LAST && !force_red) begin
          if (ns_pend_q && ew_pend_q) begin
            // Round-robin: the approach not served last wins the tie.
            state_d   = last_ns_q ? EW_GREEN : NS_GREEN;
            last_ns_d = !last_ns_q;
          end else if (ns_pend_q) begin
            state_d   = NS_GREEN;
            last_ns_d = 1'b1;
          end else if (ew_pend_q) begin
            state_d   = EW_GREEN;
            last_ns_d = 1'b0;
          end
        end
      end
      NS_GREEN: begin
        if (force_red ||
            (ew_pend_q && timer_q >= MIN_G_LAST && !ns_car) ||
            (ew_pend_q && timer_q >= MAX_G_LAST))
          state_d = NS_YELLOW;
      end
      EW_GREEN: begin
        if (force_red ||
            (ns_pend_q && timer_q >= MIN_G_LAST && !ew_car) ||
            (ns_pend_q && timer_q >= MAX_G_LAST))
          state_d = EW_YELLOW;
      end
      NS_YELLOW, EW_YELLOW: begin
        if (timer_q == YEL_LAST) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase

    // Clearing on entry to green wins over a request seen in the same cycle.
    if (state_d == NS_GREEN && state_q != NS_GREEN) ns_pend_d = 1'b0;
    else ns_pend_d = ns_pend_q | (ns_car && state_q != NS_GREEN);

    if (state_d == EW_GREEN && state_q != EW_GREEN) ew_pend_d = 1'b0;
    else ew_pend_d = ew_pend_q | (ew_car && state_q != EW_GREEN);

    if (state_d != state_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + 1'b1;
  end

  // Outputs are decoded from the next state so the registered lights line up
  // with the state register cycle for cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ALL_RED;
      timer_q      <= '0;
      ns_pend_q    <= 1'b0;
      ew_pend_q    <= 1'b0;
      last_ns_q    <= 1'b0;
      ns_light_q   <= L_RED;
      ew_light_q   <= L_RED;
      phase_done_q <= 1'b0;
      serving_ns_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ns_pend_q    <= ns_pend_d;
      ew_pend_q    <= ew_pend_d;
      last_ns_q    <= last_ns_d;
      ns_light_q   <= ns_code(state_d);
      ew_light_q   <= ew_code(state_d);
      phase_done_q <= (state_q == NS_YELLOW || state_q == EW_YELLOW) &&
                      (state_d == ALL_RED);
      serving_ns_q <= (state_d == NS_GREEN) || (state_d == NS_YELLOW);
    end
  end

  assign ns_light   = ns_light_q;
  assign ew_light   = ew_light_q;
  assign phase_done = phase_done_q;
  assign serving_ns = serving_ns_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL   = 3;
  localparam int ARED  = 2;
  localparam int TMAX  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_car = 1'b0, ew_car = 1'b0, force_red = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       phase_done, serving_ns;

  int checks = 0;
  int errors = 0;

  intersection_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_TIME(YEL),
    .ALLRED_TIME(ARED), .TW(4)
  ) dut (
    .clk(clk), .reset(reset), .ns_car(ns_car), .ew_car(ew_car),
    .force_red(force_red), .ns_light(ns_light), .ew_light(ew_light),
    .phase_done(phase_done), .serving_ns(serving_ns)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which approach holds the right of way (side), what it
  // is showing (colour), how long it has shown it (age), and the latched
  // requests.
  localparam int C_RED = 0, C_GRN = 1, C_YEL = 2;
  int colour = C_RED;
  bit side = 1'b0;       // 1 = NS owns the current green/yellow
  int age = 0;
  bit pn = 1'b0, pe = 1'b0, last = 1'b0, pd = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour = C_RED; side = 1'b0; age = 0;
      pn = 1'b0; pe = 1'b0; last = 1'b0; pd = 1'b0;
    end else begin
      int nc;
      bit nside, other, own, entered;
      nc = colour; nside = side; pd = 1'b0;
      if (colour == C_RED) begin
        if (age >= ARED - 1 && !force_red && (pn || pe)) begin
          nside = (pn && pe) ? !last : pn;
          nc = C_GRN;
          last = nside;
        end
      end else if (colour == C_GRN) begin
        other = side ? pe : pn;
        own   = side ? ns_car : ew_car;
        if (force_red || (other && age >= MIN_G - 1 && !own) ||
            (other && age >= MAX_G - 1))
          nc = C_YEL;
      end else begin
        if (age >= YEL - 1) begin nc = C_RED; pd = 1'b1; end
      end
      entered = (nc == C_GRN && colour != C_GRN);
      if (entered && nside) pn = 1'b0;
      else pn = pn | (ns_car && !(colour == C_GRN && side));
      if (entered && !nside) pe = 1'b0;
      else pe = pe | (ew_car && !(colour == C_GRN && !side));
      age = (nc != colour) ? 0 : (age < TMAX ? age + 1 : age);
      colour = nc; side = nside;
    end
  end

  function automatic int exp_light(input bit for_ns);
    if (colour == C_RED || side != for_ns) return 0;
    return (colour == C_GRN) ? 1 : 2;
  endfunction

  // Per-cycle scoreboard against the model.
  initial begin
    #3;
    forever begin
      @(negedge clk);
      chk("ns_light", int'(ns_light), exp_light(1'b1));
      chk("ew_light", int'(ew_light), exp_light(1'b0));
      chk("phase_done", int'(phase_done), int'(pd));
      chk("serving_ns", int'(serving_ns), int'(colour != C_RED && side));
    end
  end

  always @(negedge clk)
    assert (!(ns_light != 2'd0 && ew_light != 2'd0))
      else $error("both approaches non-red");

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0; ns_car = 1'b0; ew_car = 1'b0; force_red = 1'b0;
    #1;
    chk("reset_ns", int'(ns_light), 0);
    chk("reset_ew", int'(ew_light), 0);
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  // Waits (bounded) until the selected light shows GREEN at a negedge.
  task automatic wait_green(input bit for_ns, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((for_ns ? ns_light : ew_light) != 2'd1 && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) chk({name, "_timeout"}, n, 0);
  endtask

  initial begin
    int g, y, r, n, seen_pd, grants[$];
    bit prev_g, ns_g;
    #1 reset = 1'b0;
    #20;
    @(negedge clk); #1 reset = 1'b1;

    // Idle: no requests, nothing must light up.
    seen_pd = 0; n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ns_light != 0 || ew_light != 0) n++;
      if (phase_done) seen_pd++;
    end
    chk("idle_lights", n, 0);
    chk("idle_phase_done", seen_pd, 0);

    // Single NS pulse: green after the all-red clearance, then held.
    #1 ns_car = 1'b1;
    @(negedge clk); #1 ns_car = 1'b0;
    n = 0;
    while (ns_light != 2'd1 && n < 10) begin @(negedge clk); n++; end
    chk("ns_pulse_latency", n, 1);
    n = 0;
    repeat (15) begin @(negedge clk); if (ns_light == 2'd1) n++; end
    chk("ns_hold", n, 15);

    // NS holds its car, EW arrives at green cycle 2: max green applies.
    do_reset();
    ns_car = 1'b1;
    wait_green(1'b1, "max_green");
    @(negedge clk); #1 ew_car = 1'b1;
    g = 2;
    @(negedge clk);
    while (ns_light == 2'd1 && g < 40) begin g++; @(negedge clk); end
    chk("max_green_len", g, MAX_G);
    y = 0;
    while (ns_light == 2'd2 && y < 40) begin y++; @(negedge clk); end
    chk("max_yellow_len", y, YEL);
    chk("max_phase_done", int'(phase_done), 1);
    r = 0;
    while (ns_light == 0 && ew_light == 0 && r < 40) begin r++; @(negedge clk); end
    chk("max_allred_len", r, ARED);
    chk("max_then_ew", int'(ew_light), 1);

    // NS car gone, EW waiting: yields at minimum green.
    do_reset();
    ns_car = 1'b1;
    wait_green(1'b1, "min_green");
    #1 ns_car = 1'b0; ew_car = 1'b1;
    g = 1;
    @(negedge clk);
    while (ns_light == 2'd1 && g < 40) begin g++; @(negedge clk); end
    chk("min_green_len", g, MIN_G);

    // Both cars held: grants alternate NS, EW, NS, EW.
    do_reset();
    ns_car = 1'b1; ew_car = 1'b1;
    prev_g = 1'b0; n = 0;
    while (grants.size() < 4 && n < 200) begin
      @(negedge clk); n++;
      ns_g = (ns_light == 2'd1);
      if ((ns_g || ew_light == 2'd1) && !prev_g) grants.push_back(int'(ns_g));
      prev_g = ns_g || (ew_light == 2'd1);
    end
    chk("rr_count", grants.size(), 4);
    while (grants.size() < 4) grants.push_back(-1);
    chk("rr_0", grants[0], 1);
    chk("rr_1", grants[1], 0);
    chk("rr_2", grants[2], 1);
    chk("rr_3", grants[3], 0);

    // force_red at green cycle 1, held through all-red with a waiting EW.
    do_reset();
    ns_car = 1'b1;
    wait_green(1'b1, "force");
    #1 ns_car = 1'b0; force_red = 1'b1; ew_car = 1'b1;
    @(negedge clk);
    chk("force_yellow", int'(ns_light), 2);
    y = 0;
    while (ns_light == 2'd2 && y < 40) begin y++; @(negedge clk); end
    chk("force_yellow_len", y, YEL);
    n = 0;
    repeat (10) begin
      if (ns_light != 0 || ew_light != 0) n++;
      @(negedge clk);
    end
    chk("force_hold_red", n, 0);
    #1 force_red = 1'b0;
    wait_green(1'b0, "force_release");
    #1 force_red = 1'b1;
    @(negedge clk);
    chk("ew_force_yellow", int'(ew_light), 2);
    #1 reset = 1'b0;
    #1;
    chk("midyellow_reset_ns", int'(ns_light), 0);
    chk("midyellow_reset_ew", int'(ew_light), 0);
    @(negedge clk); #1 reset = 1'b1; force_red = 1'b0; ew_car = 1'b0;

    // Randomized traffic with occasional overrides and resets.
    n = 0;
    repeat (3000) begin
      @(negedge clk); #1;
      ns_car = ($urandom_range(0, 2) == 0);
      ew_car = ($urandom_range(0, 2) == 0);
      if (n > 0) n--;
      else if ($urandom_range(0, 40) == 0) n = $urandom_range(1, 12);
      force_red = (n > 0);
      reset = ($urandom_range(0, 400) != 0);
    end
    @(negedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
